reaction_timer_bcd: RTL and testbench
=====================================

# reaction_timer_bcd

Parametrised multi-player reaction timer. A start key arms a programmable delay; when the delay expires the stimulus LED lights and a packed-BCD elapsed-time counter runs until the first player's stop key is pressed. The block flags false starts, timer overflow and the winning player. It drives existing `display_7seg` instances directly with packed BCD nibbles, one nibble per HEX digit.

## Interface
Parameters:
- `PLAYERS`, 2: number of stop keys/players (1..8).
- `DIGITS`, 3: number of BCD display digits (1..6).
- `TICK_DIV`, 500000: clk cycles per time tick (0.01 s at 50 MHz); must be ≥ 2.
- `DELAY_W`, 8: width of the delay input.
- `DELAY_UNIT`, 5: ticks per delay LSB.

Ports:
- `clk` in 1: system clock.
- `key0` in 1: reset. Asynchronous, active-low.
- `start_n` in 1: start key, active-low, asynchronous to clk.
- `stop_n` in PLAYERS: per-player stop keys, active-low, asynchronous.
- `delay` in DELAY_W: pre-stimulus delay, in units of DELAY_UNIT ticks; sampled at start.
- `led` out 1: stimulus LED; high in RUN only.
- `bcd` out 4*DIGITS: elapsed ticks, packed BCD, with the LS digit at [3:0].
- `winner` out WIN_W: index of the winning or false-starting player. WIN_W = max(1, clog2(PLAYERS)).
- `winner_valid` out 1: `winner` holds a result.
- `false_start` out 1: a stop key was pressed during WAIT.
- `overflow` out 1: the counter saturated at all 9s.
- `busy` out 1: high in WAIT or RUN.
- `best_bcd` out 4*DIGITS: best (lowest) valid time; see Configuration.

## Operation
- Key inputs pass through 2-flop synchronisers. `start` is detected on the falling edge of its synchronised value. Stop keys are level-sensitive. No debounce is performed; debouncing is the caller's responsibility.
- Prescaler: counts 0..TICK_DIV-1 and asserts `tick` at TICK_DIV-1. It clears on entry to WAIT and on entry to RUN.
- FSM states and transitions:
  - IDLE: on a start edge, go to WAIT. On that transition:
    - load `dcnt` = delay*DELAY_UNIT;
    - clear `bcd`, `winner`, `winner_valid`, `false_start` and `overflow`.
  - WAIT:
    - Any stop key pressed: go to FALSE. Set `false_start`=1, `winner` = lowest pressed index, `winner_valid`=1.
    - Otherwise, if `dcnt`==0: go to RUN and set `led`=1.
    - Otherwise, on each tick, decrement `dcnt`.
    - A delay of 0 enters RUN on the cycle after WAIT is entered.
  - RUN:
    - On each tick, increment `bcd` in BCD, with a decimal carry chain.
    - Stop key pressed: go to DONE with `led`=0, `bcd` frozen, `winner` = lowest pressed index, `winner_valid`=1.
    - Tick while `bcd` is all 9s: `bcd` holds at 9..9, `overflow`=1, `winner_valid`=0, go to DONE.
    - A stop press and a tick in the same cycle: the stop wins and `bcd` is not incremented.
  - DONE / FALSE: all outputs hold. A start edge begins a new round (go to WAIT, same actions as from IDLE).
- Start edges in WAIT or RUN are ignored.
- Simultaneous stop presses: the lowest index wins.
- A stop key still held at a start edge counts as a false start on the first WAIT cycle.
- `key0` low at any time, including mid-round, forces IDLE immediately.

## Timing
- Reset values:
  - `led`, `winner`, `winner_valid`, `false_start`, `overflow` and `busy` are 0.
  - `bcd` is 0.
  - `best_bcd` is all-F, i.e. every nibble 4'hF, which displays blank.
- Key pin to FSM/output change takes 3 clk edges: 2 synchroniser edges plus 1 FSM edge.
- The first RUN tick occurs exactly TICK_DIV cycles after `led` rises.
- The WAIT duration is delay*DELAY_UNIT*TICK_DIV cycles, ±1 cycle.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- `REACTION_BEST_TIME_EN` defined:
  - `best_bcd` is a register, updated one cycle after entering DONE with `winner_valid`=1 and `bcd` < `best_bcd`.
  - The comparison is an unsigned compare of the packed nibbles, which is valid for BCD.
  - The register is cleared only by `key0`.
- Undefined: `best_bcd` is tied to all-F and no register or comparator is synthesised.

## Structure
- Package `reaction_pkg`:
  - state typedef (IDLE, WAIT, RUN, DONE, FALSE);
  - constant `BCD_BLANK` = 4'hF;
  - function `win_w(players)`.
- Sub-module `bcd_counter` (parameter DIGITS), with:
  - synchronous clear, increment enable and saturate-at-all-9s;
  - a `full` output.
- The priority encoder and the FSM live in the top module.

## Test plan
All scenarios use TICK_DIV=4, DELAY_UNIT=1, DIGITS=3, PLAYERS=2.
1. Reset then release → `led`=0, `bcd`=0x000, `busy`=0, `best_bcd`=0xFFF (with the macro).
2. delay=3, start pulse → `led` rises about 12 cycles later; stop_n[1] low after 10 ticks → `bcd`=0x010, `winner`=1, `winner_valid`=1, `led`=0.
3. delay=5, stop_n[0] low during WAIT → FALSE state, `false_start`=1, `winner`=0, `led` never rises, `bcd`=0x000.
4. In RUN, stop_n[0] and stop_n[1] asserted in the same cycle → `winner`=0.
5. No stop pressed for 1000 ticks → `bcd`=0x999, `overflow`=1, `winner_valid`=0, `busy`=0.
6. Three rounds of 25, 12 and 40 ticks → `best_bcd`=0x012; then `key0` low mid-RUN → IDLE, all outputs at reset values.

Source files
------------

// File: rtl/reaction_timer_bcd_pkg.sv
// reaction_pkg: shared types and helpers for the reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RUN,
    DONE,
    FALSE
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Width of a player index: max(1, clog2(players)).
  function automatic int unsigned win_w(input int unsigned players);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << w) < players) w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_if.sv
// reaction_timer_bcd_if: key inputs and display/status outputs of the reaction timer.
interface reaction_timer_bcd_if #(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned DELAY_W = 8
);
  localparam int unsigned WIN_W = reaction_pkg::win_w(PLAYERS);

  logic                 start_n;
  logic [PLAYERS-1:0]   stop_n;
  logic [DELAY_W-1:0]   delay;
  logic                 led;
  logic [4*DIGITS-1:0]  bcd;
  logic [WIN_W-1:0]     winner;
  logic                 winner_valid;
  logic                 false_start;
  logic                 overflow;
  logic                 busy;
  logic [4*DIGITS-1:0]  best_bcd;

  modport master (
    output start_n, stop_n, delay,
    input  led, bcd, winner, winner_valid, false_start, overflow, busy, best_bcd
  );

  modport slave (
    input  start_n, stop_n, delay,
    output led, bcd, winner, winner_valid, false_start, overflow, busy, best_bcd
  );
endinterface

// File: rtl/reaction_timer_bcd_bcd_counter.sv
// bcd_counter: packed-BCD up counter with synchronous clear, saturating at all 9s.
module bcd_counter #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                full_o
);
  logic [4*DIGITS-1:0] cnt_q, cnt_d, inc_val;
  logic                carry;

  assign full_o = (cnt_q == {DIGITS{4'd9}});
  assign bcd_o  = cnt_q;

  // Decimal carry chain and next-count selection.
  always_comb begin
    inc_val = cnt_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (inc_i && !full_o) cnt_d = inc_val;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reaction_timer_bcd.sv
// reaction_timer_bcd: multi-player reaction timer with packed-BCD elapsed time.
// Optional best-time register enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_bcd
  import reaction_pkg::*;
#(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned DELAY_W    = 8,
  parameter int unsigned DELAY_UNIT = 5
) (
  input  logic               clk,
  input  logic               key0,
  reaction_timer_bcd_if.slave io
);
  localparam int unsigned WIN_W  = win_w(PLAYERS);
  localparam int unsigned PW     = $clog2(TICK_DIV);
  localparam int unsigned DCNT_W = DELAY_W + $clog2(DELAY_UNIT + 1);
  localparam logic [4*DIGITS-1:0] BEST_RST = {DIGITS{BCD_BLANK}};

  logic               start_s1_q, start_s2_q, start_prev_q;
  logic [PLAYERS-1:0] stop_s1_q, stop_s2_q;
  logic               start_edge, any_stop;
  logic [WIN_W-1:0]   win_idx;

  state_t             state_q, state_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [PW-1:0]      pcnt_q;
  logic               tick;
  logic               led_q, busy_q;
  logic [WIN_W-1:0]   winner_q, winner_d;
  logic               valid_q, valid_d, fs_q, fs_d, ovf_q, ovf_d;
  logic               cnt_clr, cnt_inc, bcd_full;
  logic [4*DIGITS-1:0] bcd;

  // Two-flop synchronisers for the asynchronous keys plus start edge history.
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      start_s1_q   <= 1'b1;
      start_s2_q   <= 1'b1;
      start_prev_q <= 1'b1;
      stop_s1_q    <= '1;
      stop_s2_q    <= '1;
    end else begin
      start_s1_q   <= io.start_n;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      stop_s1_q    <= io.stop_n;
      stop_s2_q    <= stop_s1_q;
    end
  end

  assign start_edge = start_prev_q & ~start_s2_q;
  assign any_stop   = |(~stop_s2_q);
  assign tick       = (pcnt_q == PW'(TICK_DIV - 1));

  // Priority encoder: lowest pressed stop key wins.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = PLAYERS; i > 0; i--) begin
      if (!stop_s2_q[i-1]) win_idx = WIN_W'(i - 1);
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    winner_d = winner_q;
    valid_d  = valid_q;
    fs_d     = fs_q;
    ovf_d    = ovf_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE, DONE, FALSE: begin
        if (start_edge) begin
          state_d  = WAIT;
          dcnt_d   = DCNT_W'(io.delay) * DCNT_W'(DELAY_UNIT);
          cnt_clr  = 1'b1;
          winner_d = '0;
          valid_d  = 1'b0;
          fs_d     = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      WAIT: begin
        if (any_stop) begin
          state_d  = FALSE;
          fs_d     = 1'b1;
          winner_d = win_idx;
          valid_d  = 1'b1;
        end else if (dcnt_q == '0) begin
          state_d = RUN;
        end else if (tick) begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      RUN: begin
        if (any_stop) begin
          state_d  = DONE;
          winner_d = win_idx;
          valid_d  = 1'b1;
        end else if (tick) begin
          if (bcd_full) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, delay counter, prescaler and registered outputs.
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      winner_q <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      if ((state_d == WAIT && state_q != WAIT) || (state_d == RUN && state_q != RUN) || tick)
        pcnt_q <= '0;
      else
        pcnt_q <= pcnt_q + PW'(1);
      led_q    <= (state_d == RUN);
      busy_q   <= (state_d == WAIT) || (state_d == RUN);
      winner_q <= winner_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      ovf_q    <= ovf_d;
    end
  end

  bcd_counter #(.DIGITS(DIGITS)) u_cnt (
    .clk    (clk),
    .rst_n  (key0),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .bcd_o  (bcd),
    .full_o (bcd_full)
  );

`ifdef REACTION_BEST_TIME_EN
  logic                done_entry_q;
  logic [4*DIGITS-1:0] best_q;

  // Best-time capture one cycle after a valid finish.
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      done_entry_q <= 1'b0;
      best_q       <= BEST_RST;
    end else begin
      done_entry_q <= (state_d == DONE) && (state_q != DONE);
      if (done_entry_q && valid_q && (bcd < best_q)) best_q <= bcd;
    end
  end

  assign io.best_bcd = best_q;
`else
  assign io.best_bcd = BEST_RST;
`endif

  assign io.led          = led_q;
  assign io.busy         = busy_q;
  assign io.bcd          = bcd;
  assign io.winner       = winner_q;
  assign io.winner_valid = valid_q;
  assign io.false_start  = fs_q;
  assign io.overflow     = ovf_q;
endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Testbench for reaction_timer_bcd: directed scenarios plus randomized rounds.
module tb_reaction_timer_bcd;
  localparam int unsigned PLAYERS    = 2;
  localparam int unsigned DIGITS     = 3;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DELAY_W    = 8;
  localparam int unsigned DELAY_UNIT = 1;

  logic clk  = 1'b0;
  logic key0 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   best_ticks = -1;

  reaction_timer_bcd_if #(.PLAYERS(PLAYERS), .DIGITS(DIGITS), .DELAY_W(DELAY_W)) rif ();

  reaction_timer_bcd #(
    .PLAYERS    (PLAYERS),
    .DIGITS     (DIGITS),
    .TICK_DIV   (TICK_DIV),
    .DELAY_W    (DELAY_W),
    .DELAY_UNIT (DELAY_UNIT)
  ) dut (
    .clk  (clk),
    .key0 (key0),
    .io   (rif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] best_exp();
`ifdef REACTION_BEST_TIME_EN
    return (best_ticks < 0) ? 12'hFFF : to_bcd(best_ticks);
`else
    return 12'hFFF;
`endif
  endfunction

  function automatic int lowest(input logic [1:0] mask);
    for (int i = 0; i < 2; i++) if (mask[i]) return i;
    return 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_led"},    rif.led, 0);
    chk({pfx, "_bcd"},    rif.bcd, 0);
    chk({pfx, "_busy"},   rif.busy, 0);
    chk({pfx, "_winner"}, rif.winner, 0);
    chk({pfx, "_valid"},  rif.winner_valid, 0);
    chk({pfx, "_fs"},     rif.false_start, 0);
    chk({pfx, "_ovf"},    rif.overflow, 0);
    chk({pfx, "_best"},   rif.best_bcd, 12'hFFF);
  endtask

  task automatic do_reset();
    key0        = 1'b0;
    rif.start_n = 1'b1;
    rif.stop_n  = '1;
    rif.delay   = '0;
    cyc(2);
    check_idle_outputs("reset");
    best_ticks = -1;
    key0 = 1'b1;
    cyc(3);
  endtask

  // Drive a start press and confirm WAIT entry three edges later with cleared results.
  task automatic start_round(input int d);
    int  cnt;
    bit  found;
    rif.delay   = DELAY_W'(d);
    rif.start_n = 1'b0;
    cnt   = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1);
      cnt++;
      if (rif.busy === 1'b1) found = 1;
    end
    chk("start_to_busy", cnt, 3);
    chk("cleared_on_start",
        {rif.bcd, rif.winner, rif.winner_valid, rif.false_start, rif.overflow, rif.led}, 0);
    rif.start_n = 1'b1;
  endtask

  task automatic wait_led(input int d);
    int cnt;
    int nom;
    nom = d * DELAY_UNIT * TICK_DIV;
    cnt = 0;
    for (int i = 0; i < nom + 10; i++) begin
      cyc(1);
      cnt++;
      if (rif.led === 1'b1) break;
    end
    chk("led_rise", rif.led, 1);
    chk("wait_duration_in_range", (cnt >= nom - 1) && (cnt <= nom + 1), 1);
    chk("run_bcd_start", rif.bcd, 0);
  endtask

  // Valid round: stop pressed n cycles after the LED is seen.
  task automatic run_round(input int d, input int n, input logic [1:0] mask);
    int cnt;
    int ticks;
    start_round(d);
    wait_led(d);
    cyc(n);
    rif.stop_n = ~mask;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      cnt++;
      if (rif.led === 1'b0) break;
    end
    chk("stop_to_done", cnt, 3);
    ticks = (n + 2) / TICK_DIV;
    chk("run_bcd",    rif.bcd, to_bcd(ticks));
    chk("run_winner", rif.winner, lowest(mask));
    chk("run_valid",  rif.winner_valid, 1);
    chk("run_fs",     rif.false_start, 0);
    chk("run_ovf",    rif.overflow, 0);
    chk("run_busy",   rif.busy, 0);
    if (best_ticks < 0 || ticks < best_ticks) best_ticks = ticks;
    cyc(2);
    chk("best_after_round", rif.best_bcd, best_exp());
    rif.stop_n = '1;
    cyc(3);
  endtask

  // False start: stop either held before start or pressed during WAIT (d >= 1).
  task automatic false_round(input int d, input logic [1:0] mask, input bit held);
    int  cnt;
    bit  led_seen;
    if (held) begin
      rif.stop_n = ~mask;
      cyc(4);
    end
    start_round(d);
    if (!held) begin
      cyc(1);
      rif.stop_n = ~mask;
    end
    cnt      = 0;
    led_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rif.busy === 1'b0) break;
      if (rif.led === 1'b1) led_seen = 1;
      cyc(1);
      cnt++;
    end
    if (held) chk("held_stop_first_wait_cycle", cnt, 1);
    chk("fs_led_never",  led_seen, 0);
    chk("fs_flag",       rif.false_start, 1);
    chk("fs_winner",     rif.winner, lowest(mask));
    chk("fs_valid",      rif.winner_valid, 1);
    chk("fs_bcd",        rif.bcd, 0);
    chk("fs_ovf",        rif.overflow, 0);
    chk("fs_busy",       rif.busy, 0);
    rif.stop_n = '1;
    cyc(3);
    chk("fs_best_unchanged", rif.best_bcd, best_exp());
  endtask

  initial begin
    int cnt;
    int d;
    int n;
    int kind;
    logic [1:0] mask;

    // 1. Reset values.
    do_reset();
    check_idle_outputs("post_reset");

    // 2. delay=3, player 1 stops after 10 ticks.
    run_round(3, 10 * TICK_DIV - 2, 2'b10);

    // 3. False start during WAIT with delay 5.
    false_round(5, 2'b01, 0);

    // Stop key still held at the start edge.
    false_round(3, 2'b10, 1);

    // 4. Simultaneous stops in RUN.
    run_round(1, 21, 2'b11);

    // delay 0 enters RUN immediately.
    run_round(0, 9, 2'b01);

    // 5. Overflow after 1000 ticks with no stop.
    start_round(0);
    wait_led(0);
    cnt = 0;
    for (int i = 0; i < 1000 * TICK_DIV + 100; i++) begin
      cyc(1);
      cnt++;
      if (rif.busy === 1'b0) break;
    end
    chk("ovf_time",   cnt, 1000 * TICK_DIV);
    chk("ovf_bcd",    rif.bcd, 12'h999);
    chk("ovf_flag",   rif.overflow, 1);
    chk("ovf_valid",  rif.winner_valid, 0);
    chk("ovf_busy",   rif.busy, 0);
    chk("ovf_led",    rif.led, 0);
    cyc(3);
    chk("ovf_best_unchanged", rif.best_bcd, best_exp());

    // Randomized rounds against the arithmetic model.
    for (int r = 0; r < 10; r++) begin
      d    = int'($urandom_range(0, 4));
      n    = int'($urandom_range(0, 150));
      mask = 2'($urandom_range(1, 3));
      kind = int'($urandom_range(0, 3));
      if (kind == 0) false_round(d + 1, mask, 0);
      else           run_round(d, n, mask);
    end

    // 6. Best time over three rounds, then reset mid-RUN.
    do_reset();
    run_round(1, 25 * TICK_DIV - 2, 2'b01);
    run_round(2, 12 * TICK_DIV - 2, 2'b10);
    run_round(0, 40 * TICK_DIV - 2, 2'b01);
`ifdef REACTION_BEST_TIME_EN
    chk("best_three_rounds", rif.best_bcd, 12'h012);
`else
    chk("best_three_rounds", rif.best_bcd, 12'hFFF);
`endif
    start_round(2);
    wait_led(2);
    cyc(9);
    chk("mid_run_led", rif.led, 1);
    #2 key0 = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    best_ticks = -1;
    cyc(1);
    key0 = 1'b1;
    cyc(3);
    check_idle_outputs("after_reset_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
